// File: rtl/tt_um_bitcoin_core.sv
// tt_um_bitcoin_core
// Double SHA-256 engine for an 80-byte Bitcoin block header. The header is
// pulled in as 40 big-endian 16-bit words through a request/capture
// handshake. Three SHA-256 compressions then run on a one-round-per-cycle
// core. The 32-byte result is handed out one byte per RQ/ACK handshake.
//
// Ports
//   clk      : system clock, all state changes on the rising edge
//   rst      : synchronous active-high reset
//   ena      : unused, the design is always enabled
//   ui_in    : load phase, header data high byte; readout phase, bit 7 = ACK
//   uio_in   : load phase, header data low byte
//   uo_out   : [5:0] ADDR, [6] DONE, [7] RQ
//   uio_out  : current digest byte while reading out, otherwise 0x00
//   uio_oe   : 0xFF while reading out, otherwise 0x00
//
// Build option
//   BTC_HASH_REVERSE_EN : when defined, the digest is read out byte-reversed
//                         (Bitcoin display order) instead of in natural
//                         SHA-256 order.
module tt_um_bitcoin_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        LOAD_REQ, LOAD_CAP, HASH, OUT_REQ, OUT_WAIT, IDLE_DONE
    } state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    state_t      state, state_n;
    logic [5:0]  addr;
    logic [6:0]  rnd;
    logic [1:0]  blk;
    logic [15:0] hdr [40];
    logic [31:0] hv [8];
    logic [31:0] st [8];
    logic [31:0] w [16];
    logic [31:0] t1, t2, w_new;
    logic        ack, rq_st, done, oe_on;
    logic [4:0]  byte_idx;
    logic [31:0] dig_word;
    logic [7:0]  dig_byte;
    logic        unused_ena;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    assign ack        = ui_in[7];
    assign unused_ena = ena;

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD_REQ;
        else     state <= state_n;
    end

    // RQ is masked by rst so that it stays low for the whole reset pulse and
    // rises in the first cycle rst is released.
    always_comb begin
        state_n = state;
        rq_st   = 1'b0;
        done    = 1'b0;
        oe_on   = 1'b0;
        case (state)
            LOAD_REQ: begin
                rq_st   = 1'b1;
                state_n = LOAD_CAP;
            end
            LOAD_CAP: state_n = (addr == 6'd40) ? HASH : LOAD_REQ;
            HASH: begin
                if (rnd == 7'd64 && blk == 2'd2) state_n = OUT_REQ;
            end
            OUT_REQ: begin
                rq_st = 1'b1;
                done  = 1'b1;
                oe_on = 1'b1;
                if (ack) state_n = OUT_WAIT;
            end
            OUT_WAIT: begin
                done  = 1'b1;
                oe_on = 1'b1;
                if (!ack) state_n = (addr < 6'd32) ? OUT_REQ : IDLE_DONE;
            end
            IDLE_DONE: done = 1'b1;
            default:   state_n = LOAD_REQ;
        endcase
    end

    // One SHA-256 round. The schedule lives in a 16-word sliding window:
    // w[0] is W_t and w_new becomes W_(t+16).
    always_comb begin
        t1 = st[7] + (rotr(st[4], 6) ^ rotr(st[4], 11) ^ rotr(st[4], 25))
           + ((st[4] & st[5]) ^ (~st[4] & st[6])) + K[rnd[5:0]] + w[0];
        t2 = (rotr(st[0], 2) ^ rotr(st[0], 13) ^ rotr(st[0], 22))
           + ((st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]));
        w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
              + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
    end

    // Datapath. addr doubles as the load word index k and the readout byte
    // address. In HASH, rnd 0..63 are rounds, 64 is the final add and 65 is
    // the load of the next block. The block-1 load is folded into the
    // LOAD_CAP cycle that follows the last capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= 6'd0;
            rnd  <= 7'd0;
            blk  <= 2'd0;
            for (int i = 0; i < 8; i++) begin
                hv[i] <= 32'd0;
                st[i] <= 32'd0;
            end
            for (int i = 0; i < 16; i++) w[i] <= 32'd0;
        end else begin
            case (state)
                LOAD_REQ: begin
                    hdr[addr] <= {ui_in, uio_in};
                    addr      <= addr + 6'd1;
                end
                LOAD_CAP: begin
                    if (addr == 6'd40) begin
                        for (int i = 0; i < 8; i++) begin
                            hv[i] <= IV[i];
                            st[i] <= IV[i];
                        end
                        for (int j = 0; j < 16; j++) w[j] <= {hdr[2*j], hdr[2*j+1]};
                        rnd <= 7'd0;
                        blk <= 2'd0;
                    end
                end
                HASH: begin
                    if (rnd < 7'd64) begin
                        st[7] <= st[6];
                        st[6] <= st[5];
                        st[5] <= st[4];
                        st[4] <= st[3] + t1;
                        st[3] <= st[2];
                        st[2] <= st[1];
                        st[1] <= st[0];
                        st[0] <= t1 + t2;
                        for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                        w[15] <= w_new;
                        rnd   <= rnd + 7'd1;
                    end else if (rnd == 7'd64) begin
                        for (int i = 0; i < 8; i++) hv[i] <= hv[i] + st[i];
                        if (blk == 2'd2) addr <= 6'd0;
                        else             rnd  <= 7'd65;
                    end else begin
                        blk <= blk + 2'd1;
                        rnd <= 7'd0;
                        for (int j = 0; j < 16; j++) w[j] <= 32'd0;
                        if (blk == 2'd0) begin
                            // Second half of the header plus padding for 640 bits.
                            for (int i = 0; i < 8; i++) st[i] <= hv[i];
                            for (int j = 0; j < 4; j++) w[j] <= {hdr[32+2*j], hdr[33+2*j]};
                            w[4]  <= 32'h80000000;
                            w[15] <= 32'h00000280;
                        end else begin
                            // Second hash: first digest padded for 256 bits, fresh IV.
                            for (int i = 0; i < 8; i++) begin
                                w[i]  <= hv[i];
                                st[i] <= IV[i];
                                hv[i] <= IV[i];
                            end
                            w[8]  <= 32'h80000000;
                            w[15] <= 32'h00000100;
                        end
                    end
                end
                OUT_REQ: begin
                    if (ack) addr <= addr + 6'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
`ifdef BTC_HASH_REVERSE_EN
        byte_idx = 5'd31 - addr[4:0];
`else
        byte_idx = addr[4:0];
`endif
        dig_word = hv[byte_idx[4:2]];
        dig_byte = 8'h00;
        case (byte_idx[1:0])
            2'd0: dig_byte = dig_word[31:24];
            2'd1: dig_byte = dig_word[23:16];
            2'd2: dig_byte = dig_word[15:8];
            2'd3: dig_byte = dig_word[7:0];
        endcase
    end

    assign uo_out  = {rq_st & ~rst, done, addr};
    assign uio_oe  = oe_on ? 8'hFF : 8'h00;
    assign uio_out = (oe_on && addr < 6'd32) ? dig_byte : 8'h00;

endmodule

// File: tb/tb_tt_um_bitcoin_core.sv
// tb_tt_um_bitcoin_core
// Drives tt_um_bitcoin_core through reset, header load, hash and readout on
// a fixed cycle timeline. It uses the genesis header, aborted loads and
// hashes, and random headers. The expected outputs for every cycle come
// from the protocol timing and from a plain SHA-256 reference function.
module tb_tt_um_bitcoin_core;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_vec = 0;
    int n_bad = 0;

    logic       chk_en;
    logic       exp_rq, exp_done, exp_oe, chk_addr, chk_byte;
    logic [5:0] exp_addr;
    logic [7:0] exp_byte;

    localparam logic [639:0] GENESIS = 640'h01000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_3ba3edfd_7a7b12b2_7ac72c3e_67768f61_7fc81bc3_888a5132_3a9fb8aa_4b1e5e4a_29ab5f49_ffff001d_1dac2b7c;

    localparam logic [255:0] SHA_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    tt_um_bitcoin_core dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] wa [64];
        logic [31:0] v [8];
        logic [31:0] x1, x2, s0, s1;
        logic [255:0] hout;
        for (int t = 0; t < 16; t++) wa[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(wa[t-15], 7) ^ ror(wa[t-15], 18) ^ (wa[t-15] >> 3);
            s1 = ror(wa[t-2], 17) ^ ror(wa[t-2], 19) ^ (wa[t-2] >> 10);
            wa[t] = wa[t-16] + s0 + wa[t-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            x1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + wa[t];
            x2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + x1;
            v[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) hout[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return hout;
    endfunction

    // SHA-256 of the first len bytes of msg (len <= 119).
    function automatic logic [255:0] sha256(input logic [1023:0] msg, input int len);
        logic [1023:0] p;
        logic [255:0]  h;
        int            nb;
        p = '0;
        for (int i = 0; i < len; i++) p[1023-8*i -: 8] = msg[1023-8*i -: 8];
        p[1023-8*len -: 8] = 8'h80;
        nb = (len + 9 + 63) / 64;
        p[1023-8*(nb*64-8) -: 64] = 64'(len * 8);
        h = SHA_IV;
        for (int b = 0; b < nb; b++) h = compress(h, p[1023-512*b -: 512]);
        return h;
    endfunction

    function automatic logic [255:0] btc_double(input logic [639:0] h);
        logic [255:0] d1;
        d1 = sha256({h, 384'b0}, 80);
        return sha256({d1, 768'b0}, 32);
    endfunction

    // Byte i of the result is the i-th byte presented on uio_out.
    function automatic logic [255:0] btc_readout(input logic [639:0] h);
        logic [255:0] d2, r;
        d2 = btc_double(h);
`ifdef BTC_HASH_REVERSE_EN
        for (int i = 0; i < 32; i++) r[255-8*i -: 8] = d2[8*i +: 8];
`else
        r = d2;
`endif
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    initial begin
        check_output("model_sha256_abc", sha256({24'h616263, 1000'b0}, 3),
                     256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
        check_output("model_genesis_sha", btc_double(GENESIS),
                     256'h6fe28c0a_b6f1b372_c1a6a246_ae63f74f_931e8365_e15a089c_68d61900_00000000);
`ifdef BTC_HASH_REVERSE_EN
        check_output("model_genesis_readout", btc_readout(GENESIS),
                     256'h00000000_0019d668_9c085ae1_65831e93_4ff763ae_46a2a6c1_72b3f1b6_0a8ce26f);
`else
        check_output("model_genesis_readout", btc_readout(GENESIS),
                     256'h6fe28c0a_b6f1b372_c1a6a246_ae63f74f_931e8365_e15a089c_68d61900_00000000);
`endif
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check_output("rq", 256'(uo_out[7]), 256'(exp_rq));
                check_output("done", 256'(uo_out[6]), 256'(exp_done));
                check_output("uio_oe", 256'(uio_oe), exp_oe ? 256'hFF : 256'h00);
                if (chk_addr) check_output("addr", 256'(uo_out[5:0]), 256'(exp_addr));
                if (chk_byte) check_output("uio_out", 256'(uio_out), 256'(exp_byte));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic rq, input logic dn, input logic oe, input logic [5:0] a,
                           input logic ca, input logic [7:0] b, input logic cb);
        chk_en   = 1'b1;
        exp_rq   = rq;
        exp_done = dn;
        exp_oe   = oe;
        exp_addr = a;
        chk_addr = ca;
        exp_byte = b;
        chk_byte = cb;
    endtask

    task automatic apply_reset(input int n);
        rst    = 1'b1;
        ui_in  = 8'($urandom);
        uio_in = 8'($urandom);
        chk_en = 1'b0;
        tick();
        for (int c = 0; c < n; c++) begin
            set_exp(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 8'h00, 1'b1);
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic load_words(input logic [639:0] h, input int nwords);
        for (int k = 0; k < nwords; k++) begin
            ui_in  = h[639-16*k -: 8];
            uio_in = h[631-16*k -: 8];
            set_exp(1'b1, 1'b0, 1'b0, 6'(k), 1'b1, 8'h00, 1'b1);
            tick();
            ui_in  = 8'($urandom);
            uio_in = 8'($urandom);
            set_exp(1'b0, 1'b0, 1'b0, 6'(k + 1), 1'b1, 8'h00, 1'b1);
            tick();
        end
    endtask

    task automatic hash_phase(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            ui_in  = 8'($urandom);
            uio_in = 8'($urandom);
            set_exp(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h00, 1'b1);
            tick();
        end
    endtask

    // hi_fixed > 0 holds ACK high for exactly that many cycles per byte.
    task automatic readout(input logic [255:0] dig, input int hi_fixed);
        for (int i = 0; i < 32; i++) begin
            int         nwait;
            int         nhi;
            logic [7:0] b;
            b     = dig[255-8*i -: 8];
            nwait = int'($urandom_range(0, 2));
            nhi   = (hi_fixed > 0) ? hi_fixed : int'($urandom_range(1, 4));
            for (int c = 0; c <= nwait; c++) begin
                ui_in  = {(c == nwait), 7'($urandom)};
                uio_in = 8'($urandom);
                set_exp(1'b1, 1'b1, 1'b1, 6'(i), 1'b1, b, 1'b1);
                tick();
            end
            for (int c = 1; c < nhi; c++) begin
                ui_in = {1'b1, 7'($urandom)};
                set_exp(1'b0, 1'b1, 1'b1, 6'(i + 1), 1'b1, 8'h00, 1'b0);
                tick();
            end
            ui_in = {1'b0, 7'($urandom)};
            set_exp(1'b0, 1'b1, 1'b1, 6'(i + 1), 1'b1, 8'h00, 1'b0);
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            ui_in = 8'($urandom);
            set_exp(1'b0, 1'b1, 1'b0, 6'd32, 1'b1, 8'h00, 1'b1);
            tick();
        end
    endtask

    initial begin
        logic [255:0] exp_gen;
        logic [639:0] hdr;
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        chk_en = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h00, 1'b0);
        chk_en = 1'b0;
        exp_gen = btc_readout(GENESIS);

        // Genesis header, ACK held five cycles per byte.
        apply_reset(3);
        load_words(GENESIS, 40);
        hash_phase(197);
        readout(exp_gen, 5);

        // Abort mid-load and mid-hash, then a complete run.
        apply_reset(2);
        load_words(GENESIS, 21);
        apply_reset(2);
        load_words(GENESIS, 40);
        hash_phase(100);
        apply_reset(1);
        load_words(GENESIS, 40);
        hash_phase(197);
        readout(exp_gen, 0);

        // Random headers with random handshake timing.
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 20; j++) hdr[32*j +: 32] = $urandom;
            apply_reset(1);
            load_words(hdr, 40);
            hash_phase(197);
            readout(btc_readout(hdr), 0);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
